// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter with a start/busy/valid handshake.
// Converts one input bit per clock and latches a coherent result for the display pager.
module bcd_seq_converter #(
  parameter int unsigned WIDTH  = 30,
  parameter int unsigned DIGITS = 9,
  parameter int unsigned CNTW   = 5
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      data,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  // One extra digit beyond the presented ones, used only to flag overflow.
  localparam int unsigned ACCW = 4 * (DIGITS + 1);
  localparam int unsigned BCDW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state, state_nxt;
  logic [ACCW-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]  sh, sh_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic              busy_nxt, valid_nxt, overflow_nxt;
  logic [BCDW-1:0]   bcd_nxt;

  logic [ACCW-1:0]   acc_adj;
  logic [ACCW-1:0]   acc_shift;
  logic [WIDTH-1:0]  sh_shift;

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      sh       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      sh       <= sh_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      bcd      <= bcd_nxt;
      overflow <= overflow_nxt;
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next data bit.
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < int'(DIGITS + 1); i++) begin
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    acc_shift = ACCW'({acc_adj, sh[WIDTH-1]});
    sh_shift  = {sh[WIDTH-2:0], 1'b0};
  end

  // Next-state and registered-output logic; the final iteration publishes the result
  // so the DONE cycle can already accept the next request.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    sh_nxt       = sh;
    cnt_nxt      = cnt;
    busy_nxt     = busy;
    valid_nxt    = 1'b0;
    bcd_nxt      = bcd;
    overflow_nxt = overflow;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sh_nxt    = data;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = CONV;
        end else begin
          state_nxt = IDLE;
        end
      end
      CONV: begin
        acc_nxt = acc_shift;
        sh_nxt  = sh_shift;
        cnt_nxt = cnt + CNTW'(1);
        if (cnt == CNTW'(WIDTH - 1)) begin
          bcd_nxt      = acc_shift[BCDW-1:0];
          overflow_nxt = |acc_shift[ACCW-1 -: 4];
          valid_nxt    = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
